// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared period counter, per-channel double-buffered duty,
// optional triangular "breathe" ramp stepped once per period.
module pwm_bank #(
  parameter int unsigned CHANNELS       = 16,
  parameter int unsigned CNT_W          = 27,
  parameter int unsigned DEFAULT_PERIOD = 100_000_000,
  parameter int unsigned DEFAULT_DUTY   = 50_000_000,
  parameter int unsigned STEP           = 1_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         en,
  input  logic [CHANNELS-1:0]         breathe,
  input  logic                        wr_en,
  input  logic [$clog2(CHANNELS)-1:0] wr_addr,
  input  logic [CNT_W-1:0]            wr_data,
  input  logic                        per_wr_en,
  input  logic [CNT_W-1:0]            per_wr_data,
  output logic [CHANNELS-1:0]         out,
  output logic                        period_tick
);

  localparam int unsigned     AW       = $clog2(CHANNELS);
  localparam logic [CNT_W-1:0] PER_RST  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DEFAULT_DUTY);
  localparam logic [CNT_W-1:0] STEP_V   = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_act;
  logic             wrap;

  logic [CNT_W-1:0] duty_sh  [CHANNELS];
  logic [CNT_W-1:0] duty_act [CHANNELS];
  logic [CNT_W-1:0] duty_nxt [CHANNELS];
  logic [CNT_W:0]   up_sum   [CHANNELS];
  dir_t             dir      [CHANNELS];
  dir_t             dir_nxt  [CHANNELS];

  assign wrap = (cnt == period_act - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_sh   <= PER_RST;
      period_act  <= PER_RST;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (wrap) begin
        cnt        <= '0;
        period_act <= period_sh;
      end else begin
        cnt <= cnt + ONE;
      end
      if (per_wr_en) begin
        period_sh <= (per_wr_data < MIN_PER) ? MIN_PER : per_wr_data;
      end
    end
  end

  // Ramp ceiling is the period about to start (period_sh), not the one ending.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      up_sum[i]   = {1'b0, duty_act[i]} + {1'b0, STEP_V};
      duty_nxt[i] = duty_sh[i];
      dir_nxt[i]  = DIR_UP;
      if (breathe[i]) begin
        if (dir[i] == DIR_UP) begin
          if (up_sum[i] >= {1'b0, period_sh}) begin
            duty_nxt[i] = period_sh;
            dir_nxt[i]  = DIR_DOWN;
          end else begin
            duty_nxt[i] = up_sum[i][CNT_W-1:0];
          end
        end else begin
          if (duty_act[i] <= STEP_V) begin
            duty_nxt[i] = '0;
          end else begin
            duty_nxt[i] = duty_act[i] - STEP_V;
            dir_nxt[i]  = DIR_DOWN;
          end
        end
      end
    end
  end

  // Addresses beyond CHANNELS-1 match no channel and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= DUTY_RST;
        duty_act[i] <= DUTY_RST;
        dir[i]      <= DIR_UP;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          duty_sh[i] <= wr_data;
        end
        if (wrap) begin
          duty_act[i] <= duty_nxt[i];
          dir[i]      <= dir_nxt[i];
        end
        out[i] <= en[i] & (cnt < duty_act[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: directed scenarios plus random traffic, checked every cycle
// against an integer reference model of the period/duty/breathe rules.
module tb_pwm_bank;

  localparam int NCH   = 4;
  localparam int PER0  = 10;
  localparam int DUTY0 = 5;
  localparam int STP   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = '0;
  logic [3:0] breathe = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       per_wr_en = 1'b0;
  logic [7:0] per_wr_data = '0;
  logic [3:0] out;
  logic       period_tick;

  pwm_bank #(
    .CHANNELS(NCH), .CNT_W(8), .DEFAULT_PERIOD(PER0),
    .DEFAULT_DUTY(DUTY0), .STEP(STP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .breathe(breathe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .per_wr_en(per_wr_en), .per_wr_data(per_wr_data),
    .out(out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers, phase within period and per-channel level.
  int         m_cnt, m_per_act, m_per_sh;
  int         m_sh [NCH];
  int         m_act [NCH];
  bit         m_up [NCH];
  logic [3:0] m_out;
  logic       m_tick;

  function automatic void model_reset();
    m_cnt = 0; m_per_act = PER0; m_per_sh = PER0;
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = DUTY0; m_act[i] = DUTY0; m_up[i] = 1'b1;
    end
    m_out = '0; m_tick = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [3:0] o;
    bit wrap;
    int nper;
    wrap = (m_cnt == m_per_act - 1);
    for (int i = 0; i < NCH; i++) o[i] = en[i] && (m_cnt < m_act[i]);
    if (wrap) begin
      nper = m_per_sh;
      for (int i = 0; i < NCH; i++) begin
        if (!breathe[i]) begin
          m_act[i] = m_sh[i]; m_up[i] = 1'b1;
        end else if (m_up[i]) begin
          if (m_act[i] + STP >= nper) begin m_act[i] = nper; m_up[i] = 1'b0; end
          else m_act[i] = m_act[i] + STP;
        end else begin
          if (m_act[i] <= STP) begin m_act[i] = 0; m_up[i] = 1'b1; end
          else m_act[i] = m_act[i] - STP;
        end
      end
      m_per_act = nper;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    if (wr_en) m_sh[wr_addr] = wr_data;
    if (per_wr_en) m_per_sh = (per_wr_data < 2) ? 2 : int'(per_wr_data);
    m_out = o;
    m_tick = wrap;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    chk("out", out, m_out);
    chk("period_tick", period_tick, m_tick);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_cnt(input int c);
    for (int k = 0; k < 40 && m_cnt != c; k++) tick();
  endtask

  task automatic gap_to_tick(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (period_tick !== 1'b1 && n < 60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int g;
  int hi;
  int exp_ramp [11] = '{5, 7, 9, 10, 8, 6, 4, 2, 0, 2, 4};

  initial begin
    model_reset();
    run(3);
    chk("reset_out", out, 0);
    chk("reset_tick", period_tick, 0);

    // 1: default 5-high/5-low, tick every 10
    rst_n = 1'b1; en = 4'hF;
    run(30);
    gap_to_tick(g);
    gap_to_tick(g);
    chk("t1_tick_gap", g, 10);

    // 2: ch1 duty 3 written mid-period
    wait_cnt(2);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'd3;
    tick();
    wr_en = 1'b0;
    run(25);

    // 3: ch0 duty 0, ch3 duty above period
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd0;
    tick();
    wr_addr = 2'd3; wr_data = 8'd12;
    tick();
    wr_en = 1'b0;
    run(25);

    // 4: period write on wrap cycle, then clamp of 0 to 2
    wait_cnt(9);
    per_wr_en = 1'b1; per_wr_data = 8'd4;
    tick();
    per_wr_en = 1'b0;
    gap_to_tick(g);
    chk("t4_gap_old", g, 10);
    gap_to_tick(g);
    chk("t4_gap_new", g, 4);
    per_wr_en = 1'b1; per_wr_data = 8'd0;
    tick();
    per_wr_en = 1'b0;
    run(12);
    gap_to_tick(g);
    gap_to_tick(g);
    chk("t4_gap_clamp", g, 2);

    // 5: breathe ramp on ch2
    per_wr_en = 1'b1; per_wr_data = 8'd10;
    tick();
    per_wr_en = 1'b0;
    run(20);
    wait_cnt(0);
    breathe = 4'b0100;
    for (int k = 0; k < 11; k++) begin
      hi = 0;
      repeat (10) begin
        tick();
        hi += int'(out[2]);
      end
      chk($sformatf("t5_ramp%0d", k), hi, exp_ramp[k]);
    end
    breathe = '0;
    run(25);

    // 6: async reset mid-period
    wait_cnt(6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_out", out, 0);
    chk("t6_async_tick", period_tick, 0);
    run(2);
    rst_n = 1'b1;
    run(25);
    gap_to_tick(g);
    gap_to_tick(g);
    chk("t6_tick_gap", g, 10);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      en          = 4'($urandom);
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_addr     = 2'($urandom);
      wr_data     = 8'($urandom_range(0, 15));
      per_wr_en   = ($urandom_range(0, 15) == 0);
      per_wr_data = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) breathe = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
